// File: rtl/gpio_cfg_sequencer.sv
// Staged per-pad GPIO configuration with a hold-protected commit sequence (IDLE/HOLD/LOAD/SETTLE/RELEASE).
// Define GPIO_CFG_READBACK_EN to add a registered readback port for the staging words.
module gpio_cfg_sequencer #(
    parameter int NUM_PADS      = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [3:0]            cfg_addr,
    input  logic [12:0]           cfg_data,
    input  logic                  apply_req,
    output logic                  apply_busy,
    output logic                  apply_done,
    output logic [3*NUM_PADS-1:0] dm,
    output logic [NUM_PADS-1:0]   oeb,
    output logic [NUM_PADS-1:0]   inp_dis,
    output logic [NUM_PADS-1:0]   ib_mode_sel,
    output logic [NUM_PADS-1:0]   vtrip_sel,
    output logic [NUM_PADS-1:0]   slow_sel,
    output logic [NUM_PADS-1:0]   holdover,
    output logic [NUM_PADS-1:0]   analog_en,
    output logic [NUM_PADS-1:0]   analog_sel,
    output logic [NUM_PADS-1:0]   analog_pol,
    output logic [NUM_PADS-1:0]   enh,
    output logic [NUM_PADS-1:0]   hldh_n
`ifdef GPIO_CFG_READBACK_EN
    ,
    input  logic [3:0]            rd_addr,
    output logic [12:0]           rd_data
`endif
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [12:0] PAD_RESET = 13'h0009;

    typedef enum logic [2:0] {IDLE, HOLD, LOAD, SETTLE, RELEASE} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  settle_cnt;
    logic [12:0]       staging [NUM_PADS];
    logic [12:0]       active  [NUM_PADS];
    logic              pend_valid;
    logic [3:0]        pend_addr;
    logic [12:0]       pend_data;
    logic              addr_ok;
    logic              wr_en;
    logic              settle_last;

    assign addr_ok     = {1'b0, cfg_addr} < 5'(NUM_PADS);
    assign cfg_ready   = (state != LOAD);
    assign wr_en       = cfg_valid && cfg_ready && addr_ok;
    assign settle_last = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign apply_busy  = (state != IDLE);
    assign apply_done  = (state == RELEASE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (apply_req) state_next = HOLD;
            HOLD:    state_next = LOAD;
            LOAD:    state_next = SETTLE;
            SETTLE:  if (settle_last) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_last ? '0 : settle_cnt + CNT_W'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // A write landing in HOLD belongs to the next commit, so park it until LOAD has taken its snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else if (state == HOLD) begin
            pend_valid <= wr_en;
            pend_addr  <= cfg_addr;
            pend_data  <= cfg_data;
        end else if (state == LOAD) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PADS; p++) begin
            if (reset) begin
                staging[p] <= PAD_RESET;
                active[p]  <= PAD_RESET;
            end else if (state == LOAD) begin
                active[p] <= staging[p];
                if (pend_valid && pend_addr == 4'(p)) staging[p] <= pend_data;
            end else if (wr_en && state != HOLD && cfg_addr == 4'(p)) begin
                staging[p] <= cfg_data;
            end
        end
    end

    always_comb begin
        dm          = '0;
        oeb         = '0;
        inp_dis     = '0;
        ib_mode_sel = '0;
        vtrip_sel   = '0;
        slow_sel    = '0;
        holdover    = '0;
        analog_en   = '0;
        analog_sel  = '0;
        analog_pol  = '0;
        enh         = '0;
        hldh_n      = '1;
        for (int p = 0; p < NUM_PADS; p++) begin
            dm[3*p +: 3]   = active[p][2:0];
            oeb[p]         = active[p][3];
            inp_dis[p]     = active[p][4];
            ib_mode_sel[p] = active[p][5];
            vtrip_sel[p]   = active[p][6];
            slow_sel[p]    = active[p][7];
            holdover[p]    = active[p][8];
            analog_en[p]   = active[p][9];
            analog_sel[p]  = active[p][10];
            analog_pol[p]  = active[p][11];
            enh[p]         = active[p][12];
            if (state == HOLD || state == SETTLE) hldh_n[p] = ~active[p][12];
        end
    end

`ifdef GPIO_CFG_READBACK_EN
    logic [12:0] rd_word;

    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (rd_addr == 4'(p)) rd_word = staging[p];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_word;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Self-checking bench for gpio_cfg_sequencer: directed scenarios plus randomized traffic against a
// commit-timeline reference model; a second 8-pad instance covers out-of-range addresses.
module tb_gpio_cfg_sequencer;

    localparam int NP   = 16;
    localparam int SC   = 4;
    localparam int LAST = 3 + SC;
    localparam logic [12:0] PAD_RST = 13'h0009;

    logic            clock = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [3:0]      cfg_addr;
    logic [12:0]     cfg_data;
    logic            apply_req;
    logic            apply_busy;
    logic            apply_done;
    logic [3*NP-1:0] dm;
    logic [NP-1:0]   oeb, inp_dis, ib_mode_sel, vtrip_sel, slow_sel, holdover;
    logic [NP-1:0]   analog_en, analog_sel, analog_pol, enh, hldh_n;
    logic [3:0]      rd_addr;
    logic [12:0]     rd_data;

    logic            s_valid, s_ready, s_req, s_busy, s_done;
    logic [3:0]      s_addr;
    logic [12:0]     s_data;
    logic [23:0]     s_dm;
    logic [7:0]      s_oeb, s_inp_dis, s_ib_mode_sel, s_vtrip_sel, s_slow_sel, s_holdover;
    logic [7:0]      s_analog_en, s_analog_sel, s_analog_pol, s_enh, s_hldh_n;
    logic [3:0]      s_rd_addr;
    logic [12:0]     s_rd_data;

    always #5 clock = ~clock;

    gpio_cfg_sequencer #(.NUM_PADS(NP), .SETTLE_CYCLES(SC)) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .apply_req(apply_req),
        .apply_busy(apply_busy), .apply_done(apply_done), .dm(dm), .oeb(oeb),
        .inp_dis(inp_dis), .ib_mode_sel(ib_mode_sel), .vtrip_sel(vtrip_sel),
        .slow_sel(slow_sel), .holdover(holdover), .analog_en(analog_en),
        .analog_sel(analog_sel), .analog_pol(analog_pol), .enh(enh), .hldh_n(hldh_n)
`ifdef GPIO_CFG_READBACK_EN
        , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
    );

    gpio_cfg_sequencer #(.NUM_PADS(8), .SETTLE_CYCLES(2)) small_dut (
        .clock(clock), .reset(reset), .cfg_valid(s_valid), .cfg_ready(s_ready),
        .cfg_addr(s_addr), .cfg_data(s_data), .apply_req(s_req),
        .apply_busy(s_busy), .apply_done(s_done), .dm(s_dm), .oeb(s_oeb),
        .inp_dis(s_inp_dis), .ib_mode_sel(s_ib_mode_sel), .vtrip_sel(s_vtrip_sel),
        .slow_sel(s_slow_sel), .holdover(s_holdover), .analog_en(s_analog_en),
        .analog_sel(s_analog_sel), .analog_pol(s_analog_pol), .enh(s_enh), .hldh_n(s_hldh_n)
`ifdef GPIO_CFG_READBACK_EN
        , .rd_addr(s_rd_addr), .rd_data(s_rd_data)
`endif
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: m_k counts cycles since the commit was accepted (0 = idle).
    logic [12:0] m_staging [NP];
    logic [12:0] m_active  [NP];
    logic [12:0] m_snap    [NP];
    int          m_k;
    bit          m_known;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            fails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge: check the current cycle, drive inputs, advance the model one edge.
    task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [12:0] d,
                                 input logic req, input logic rst);
        logic [13*NP-1:0] obs_pads;
        logic [13*NP-1:0] exp_pads;
        logic [NP-1:0]    exp_hldh;
        bit               holding;
        if (m_known) begin
            holding = (m_k == 1) || (m_k >= 3 && m_k <= 2 + SC);
            for (int p = 0; p < NP; p++) begin
                obs_pads[13*p +: 13] = {enh[p], analog_pol[p], analog_sel[p], analog_en[p],
                                        holdover[p], slow_sel[p], vtrip_sel[p], ib_mode_sel[p],
                                        inp_dis[p], oeb[p], dm[3*p +: 3]};
                exp_pads[13*p +: 13] = m_active[p];
                exp_hldh[p] = holding ? ~m_active[p][12] : 1'b1;
            end
            checkOutput("pads", obs_pads, exp_pads);
            checkOutput("hldh_n", hldh_n, exp_hldh);
            checkOutput("apply_busy", apply_busy, m_k != 0);
            checkOutput("apply_done", apply_done, m_k == LAST);
            checkOutput("cfg_ready", cfg_ready, m_k != 2);
        end
        cfg_valid = v;
        cfg_addr  = a;
        cfg_data  = d;
        apply_req = req;
        reset     = rst;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                m_staging[p] = PAD_RST;
                m_active[p]  = PAD_RST;
            end
            m_k     = 0;
            m_known = 1'b1;
        end else begin
            if (v && m_k != 2 && a < NP) m_staging[a] = d;
            if (m_k == 2) m_active = m_snap;
            if (m_k == 0) begin
                if (req) begin
                    m_snap = m_staging;
                    m_k    = 1;
                end
            end else begin
                m_k = (m_k == LAST) ? 0 : m_k + 1;
            end
        end
        @(negedge clock);
    endtask

    task automatic idleCycles(input int n, output int done_count);
        done_count = 0;
        for (int i = 0; i < n; i++) begin
            if (apply_done === 1'b1) done_count++;
            applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int done_at;
        int low_cycles;
        int dones;
        int s_dones;
        reset = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; apply_req = 1'b0; rd_addr = '0;
        s_valid = 1'b0; s_addr = '0; s_data = '0; s_req = 1'b0; s_rd_addr = '0;
        m_known = 1'b0;
        m_k = 0;
        @(negedge clock);
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);

        checkOutput("rst_dm", dm, 48'h249249249249);
        checkOutput("rst_oeb", oeb, 16'hFFFF);
        checkOutput("rst_enh", enh, 16'h0000);
        checkOutput("rst_hldh_n", hldh_n, 16'hFFFF);
        checkOutput("rst_busy", apply_busy, 1'b0);

        // Pad 3 commit: latency and hold window
        applyStimulus(1'b1, 4'd3, 13'h1006, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b1, 1'b0);
        done_at = 0;
        low_cycles = 0;
        for (int i = 1; i <= 12; i++) begin
            if (apply_done === 1'b1 && done_at == 0) done_at = i;
            if (hldh_n[3] === 1'b0) low_cycles++;
            if (i <= 2) checkOutput("pad3_before_load", dm[11:9], 3'b001);
            applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);
        end
        checkOutput("commit_latency", done_at, 7);
        checkOutput("pad3_hold_cycles", low_cycles, 4);
        checkOutput("pad3_dm", dm[11:9], 3'b110);
        checkOutput("pad3_oeb", oeb[3], 1'b0);
        checkOutput("pad3_enh", enh[3], 1'b1);

        // Write and apply in the same cycle
        applyStimulus(1'b1, 4'd5, 13'h0035, 1'b1, 1'b0);
        idleCycles(9, dones);
        checkOutput("pad5_dm", dm[17:15], 3'b101);
        checkOutput("pad5_inp_dis", inp_dis[5], 1'b1);

        // Write plus ignored apply during SETTLE
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b1, 1'b0);
        idleCycles(2, dones);
        applyStimulus(1'b1, 4'd7, 13'h0002, 1'b1, 1'b0);
        idleCycles(8, dones);
        checkOutput("pad7_first_commit", dm[23:21], 3'b001);
        checkOutput("single_done", dones, 1);
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b1, 1'b0);
        idleCycles(9, dones);
        checkOutput("pad7_second_commit", dm[23:21], 3'b010);

        // Reset during SETTLE aborts the commit
        applyStimulus(1'b1, 4'd9, 13'h1fff, 1'b1, 1'b0);
        idleCycles(3, dones);
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b1);
        checkOutput("abort_no_done", apply_done, 1'b0);
        checkOutput("abort_dm", dm, 48'h249249249249);
        checkOutput("abort_enh", enh, 16'h0000);
        checkOutput("abort_hldh_n", hldh_n, 16'hFFFF);
        idleCycles(10, dones);
        checkOutput("abort_done_count", dones, 0);

`ifdef GPIO_CFG_READBACK_EN
        applyStimulus(1'b1, 4'd3, 13'h1006, 1'b0, 1'b0);
        rd_addr = 4'd3;
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);
        checkOutput("readback_pad3", rd_data, 13'h1006);
`endif

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 13'($urandom),
                          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 59) == 0));
        end
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b1);

        // 8-pad instance: address 15 must be discarded
        s_valid = 1'b1; s_addr = 4'd15; s_data = 13'h1fff;
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);
        s_valid = 1'b0; s_req = 1'b1;
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);
        s_req = 1'b0;
        s_dones = 0;
        for (int i = 0; i < 7; i++) begin
            if (s_done === 1'b1) s_dones++;
            applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);
        end
        checkOutput("small_done_count", s_dones, 1);
        checkOutput("small_dm", s_dm, 24'h249249);
        checkOutput("small_oeb", s_oeb, 8'hFF);
        checkOutput("small_enh", s_enh, 8'h00);
        s_valid = 1'b1; s_addr = 4'd2; s_data = 13'h1006; s_req = 1'b1;
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);
        s_valid = 1'b0; s_req = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);
        checkOutput("small_pad2_dm", s_dm[8:6], 3'b110);
`ifdef GPIO_CFG_READBACK_EN
        s_rd_addr = 4'd15;
        applyStimulus(1'b0, 4'd0, 13'd0, 1'b0, 1'b0);
        checkOutput("small_readback_oob", s_rd_data, 13'h0000);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
